// File: rtl/alu_wb_fifo.sv
// alu_wb_fifo: in-order ALU result buffer feeding writeback; define ALU_WB_BYPASS_EN for an empty-buffer bypass
module alu_wb_fifo #(
  parameter int XLEN          = 64,
  parameter int TRANS_ID_BITS = 3,
  parameter int DEPTH         = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     alu_valid_i,
  output logic                     alu_ready_o,
  input  logic [TRANS_ID_BITS-1:0] alu_trans_id_i,
  input  logic [XLEN-1:0]          alu_result_i,
  input  logic                     alu_branch_res_i,
  output logic                     wb_valid_o,
  input  logic                     wb_ready_i,
  output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
  output logic [XLEN-1:0]          wb_result_o,
  output logic                     wb_branch_res_o,
  output logic [$clog2(DEPTH):0]   occupancy_o,
  output logic                     overflow_o
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  logic [TRANS_ID_BITS-1:0] id_mem [DEPTH];
  logic [XLEN-1:0]          res_mem [DEPTH];
  logic [DEPTH-1:0]         br_mem;
  logic [PW-1:0]            rd_ptr, wr_ptr;
  logic [PW:0]              count;
  logic                     overflow, stored, push, pop, write, bypass;
  assign stored      = count != '0;
  assign alu_ready_o = count != FULL;
  assign push        = alu_valid_i & alu_ready_o;
  assign pop         = stored & wb_ready_i;
`ifdef ALU_WB_BYPASS_EN
  assign bypass = ~stored & alu_valid_i & ~flush_i;
`else
  assign bypass = 1'b0;
`endif
  // A bypassed result taken by the arbiter in the same cycle never enters storage
  assign write       = push & ~(bypass & wb_ready_i);
  assign wb_valid_o  = stored | bypass;
  assign occupancy_o = count;
  assign overflow_o  = overflow;
  // Head presentation: bypass path, stored head, or zeros when nothing is valid
  always_comb begin
    wb_trans_id_o   = bypass ? alu_trans_id_i   : stored ? id_mem[rd_ptr]  : '0;
    wb_result_o     = bypass ? alu_result_i     : stored ? res_mem[rd_ptr] : '0;
    wb_branch_res_o = bypass ? alu_branch_res_i : stored & br_mem[rd_ptr];
  end
  // Storage array, written at the write pointer; left unreset on purpose
  always_ff @(posedge clk_i) begin
    if (write) begin
      id_mem[wr_ptr]  <= alu_trans_id_i;
      res_mem[wr_ptr] <= alu_result_i;
      br_mem[wr_ptr]  <= alu_branch_res_i;
    end
  end
  // Pointers, count and sticky overflow; reset and flush both empty the buffer
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (write) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (write && !pop) count <= count + 1'b1;
      else if (pop && !write) count <= count - 1'b1;
      if (alu_valid_i && !alu_ready_o) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_alu_wb_fifo.sv
// tb_alu_wb_fifo: scoreboard bench for alu_wb_fifo with a queue-based reference model
module tb_alu_wb_fifo;
  localparam int DEPTH = 4;
`ifdef ALU_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  typedef struct {
    logic [2:0]  id;
    logic [63:0] res;
    logic        br;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        alu_valid = 1'b0;
  logic        alu_ready;
  logic [2:0]  alu_id = '0;
  logic [63:0] alu_res = '0;
  logic        alu_br = 1'b0;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [2:0]  wb_id;
  logic [63:0] wb_res;
  logic        wb_br;
  logic [2:0]  occupancy;
  logic        overflow;

  entry_t exp_q[$];
  bit     m_ovf = 1'b0;
  bit     armed = 1'b0;
  int     n_checks = 0;
  int     n_fail = 0;

  alu_wb_fifo #(.XLEN(64), .TRANS_ID_BITS(3), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .alu_valid_i(alu_valid), .alu_ready_o(alu_ready),
    .alu_trans_id_i(alu_id), .alu_result_i(alu_res), .alu_branch_res_i(alu_br),
    .wb_valid_o(wb_valid), .wb_ready_i(wb_ready),
    .wb_trans_id_o(wb_id), .wb_result_o(wb_res), .wb_branch_res_o(wb_br),
    .occupancy_o(occupancy), .overflow_o(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Monitor: compares everything the DUT presents just before each rising edge
  initial begin
    entry_t e;
    bit byp;
    forever begin
      @(negedge clk);
      #3;
      if (armed) begin
        byp = BYP && exp_q.size() == 0 && alu_valid && !flush;
        chk("occupancy", 64'(occupancy), 64'(exp_q.size()));
        chk("alu_ready", 64'(alu_ready), 64'(exp_q.size() != DEPTH));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("wb_valid", 64'(wb_valid), 64'(exp_q.size() != 0 || byp));
        if (byp) e = '{alu_id, alu_res, alu_br};
        else if (exp_q.size() != 0) e = exp_q[0];
        else e = '{3'd0, 64'd0, 1'b0};
        chk("wb_trans_id", 64'(wb_id), 64'(e.id));
        chk("wb_result", wb_res, e.res);
        chk("wb_branch_res", 64'(wb_br), 64'(e.br));
        if (wb_ready && !byp && exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end
  end

  // One clock of stimulus; the model is committed after the monitor has consumed this cycle
  task automatic cyc(input bit v, input logic [2:0] id, input logic [63:0] r, input bit b,
                     input bit rdy, input bit fl, input bit rst);
    bit full, empty;
    @(negedge clk);
    alu_valid = v; alu_id = id; alu_res = r; alu_br = b;
    wb_ready = rdy; flush = fl; rst_n = !rst;
    full = exp_q.size() == DEPTH;
    empty = exp_q.size() == 0;
    #4;
    if (rst || fl) begin
      exp_q.delete();
      m_ovf = 1'b0;
    end else if (v && full) m_ovf = 1'b1;
    else if (v && !(BYP && empty && rdy)) exp_q.push_back('{id, r, b});
    armed = 1'b1;
  endtask

  initial begin
    int pv, pr;
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(1, 3'd1, 64'h1234, 1, 1, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 3'(i), 64'hA0 + 64'(i), 0, 0, 0, 0);
    cyc(1, 3'd5, 64'hFF, 1, 0, 0, 0);
    repeat (4) cyc(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 2; i++) cyc(1, 3'(i), 64'hB0 + 64'(i), 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(1, 3'((i + 2) % 8), 64'hC0 + 64'(i), i[0], 1, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 3'(i), 64'hD0 + 64'(i), 0, 0, 0, 0);
    cyc(1, 3'd7, 64'hDEAD, 1, 0, 1, 0);
    repeat (2) cyc(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 2; i++) cyc(1, 3'(i), 64'hE0 + 64'(i), 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(1, 3'd3, 64'hBEEF, 1, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(1, 3'd3, 64'hBEEF, 1, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 1, 0, 0);
    pv = 50; pr = 50;
    for (int n = 0; n < 1000; n++) begin
      if (n % 50 == 0) begin
        pv = $urandom_range(10, 95);
        pr = $urandom_range(10, 95);
      end
      cyc($urandom_range(99) < pv, 3'($urandom), {$urandom, $urandom}, 1'($urandom),
          $urandom_range(99) < pr, $urandom_range(99) < 3, $urandom_range(199) < 1);
    end
    repeat (2) cyc(0, 0, 0, 0, 1, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
